// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: direction/mode encodings and prescaler sizing shared by timer_bank and timer_channel
package timer_bank_pkg;
  localparam logic TIMER_DIR_UP = 1'b1;
  localparam logic TIMER_DIR_DOWN = 1'b0;
  localparam logic TIMER_MODE_PERIODIC = 1'b0;
  localparam logic TIMER_MODE_ONESHOT = 1'b1;
  function automatic int presc_width(input int clks);
    return (clks > 2) ? $clog2(clks) : 1;
  endfunction
endpackage

// File: rtl/timer_channel.sv
// timer_channel: one up/down, periodic/one-shot counter advanced by the shared tick
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         tick,
  input  logic         load,
  input  logic         up,
  input  logic         oneshot,
  input  logic         enable,
  input  logic [W-1:0] max_val,
  input  logic [W-1:0] start_val,
  output logic [W-1:0] value,
  output logic         running,
  output logic         expired
);
  logic dir, mode, adv, term, stop, is_up;
  logic [W-1:0] top, next_val;
  always_comb begin
    top = max_val - W'(1);
    is_up = dir == TIMER_DIR_UP;
    stop = mode == TIMER_MODE_ONESHOT;
    adv = tick & enable & running & ~load & (max_val != '0);
    // >= rather than == so a max lowered below the count still terminates
    term = is_up ? (value >= top) : (value == '0);
    next_val = !term ? (is_up ? value + W'(1) : value - W'(1))
             : is_up ? (stop ? top : '0) : (stop ? '0 : top);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      dir <= 1'b0;
      mode <= 1'b0;
    end else if (load) begin
      dir <= up;
      mode <= oneshot;
      value <= up ? '0 : start_val;
      running <= 1'b1;
      expired <= 1'b0;
    end else begin
      expired <= adv & term;
      if (adv) begin
        value <= next_val;
        if (term & stop) running <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/timer_bank.sv
// timer_bank: N_CH millisecond timers sharing one tick prescaler.
// Optional TIMER_BANK_IRQ_EN adds sticky irq_status/irq with per-channel irq_clr.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int W = 16,
  parameter int CLKS_PER_TICK = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_CH-1:0]   load,
  input  logic [N_CH-1:0]   up,
  input  logic [N_CH-1:0]   oneshot,
  input  logic [N_CH-1:0]   enable,
  input  logic [N_CH*W-1:0] max_val,
  input  logic [N_CH*W-1:0] start_val,
  output logic [N_CH*W-1:0] value,
  output logic [N_CH-1:0]   running,
  output logic [N_CH-1:0]   expired
`ifdef TIMER_BANK_IRQ_EN
  ,
  input  logic [N_CH-1:0]   irq_clr,
  output logic [N_CH-1:0]   irq_status,
  output logic              irq
`endif
);
  localparam int PW = presc_width(CLKS_PER_TICK);
  logic [PW-1:0] presc;
  logic tick;
  assign tick = presc == PW'(CLKS_PER_TICK - 1);
  always_ff @(posedge clk) begin
    if (reset) presc <= '0;
    else presc <= tick ? '0 : presc + PW'(1);
  end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_channel #(.W(W)) u_ch (
      .clk(clk),
      .reset(reset),
      .tick(tick),
      .load(load[g]),
      .up(up[g]),
      .oneshot(oneshot[g]),
      .enable(enable[g]),
      .max_val(max_val[g*W +: W]),
      .start_val(start_val[g*W +: W]),
      .value(value[g*W +: W]),
      .running(running[g]),
      .expired(expired[g])
    );
  end
`ifdef TIMER_BANK_IRQ_EN
  logic [N_CH-1:0] status_next;
  assign status_next = (irq_status & ~irq_clr) | expired;
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_status <= '0;
      irq <= 1'b0;
    end else begin
      irq_status <= status_next;
      irq <= |status_next;
    end
  end
`endif
endmodule
